layer1_mac_engine: RTL and testbench
====================================

Name: layer1_mac_engine

Overview:
Sequencer and multiply-accumulate datapath for the first fully connected layer. Drives the address port of the weight ROM (combinational read, 32-bit signed fixed-point) and of the input-vector store. Computes one dot product per output neuron. Emits each result as a saturated 32-bit fixed-point value with a one-cycle valid pulse.

Parameters:
N_IN, 784, inputs per neuron (row length of weight matrix)
N_OUT, 64, output neurons (rows)
DATA_W, 32, weight/input/output width, signed two's complement
FRAC_BITS, 16, fractional bits of all DATA_W operands
ADDR_W, 16, weight address width; N_IN*N_OUT must be <= 2^ADDR_W
X_ADDR_W, 10, input-vector address width; N_IN must be <= 2^X_ADDR_W
ACC_W, 64, accumulator width

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  begin layer computation; sampled only in IDLE
w_addr  output  ADDR_W  weight ROM address, row-major: neuron*N_IN + i
w_data  input  DATA_W  weight ROM data, valid combinationally from w_addr in same cycle
x_addr  output  X_ADDR_W  input-vector address i
x_data  input  DATA_W  input-vector data, valid combinationally from x_addr in same cycle
y_valid  output  1  one-cycle pulse, y_data/y_index valid
y_index  output  log2(N_OUT) (min 1)  neuron index of y_data
y_data  output  DATA_W  neuron result
busy  output  1  high from the edge accepting start to the edge asserting done
done  output  1  one-cycle pulse after the last neuron

Behaviour:
- Reset (async, resetn=0): state=IDLE; w_addr, x_addr, y_index, y_data, acc, counters = 0; y_valid, busy, done = 0. Reset mid-operation abandons the layer; no partial y_valid follows.
- States: IDLE, RUN, WRITE, DONE.
- IDLE: start=1 at an edge -> RUN; busy<=1; acc<=0; i<=0; neuron<=0; w_addr<=0; x_addr<=0.
- RUN, every edge: acc <= acc + sext(w_data) * sext(x_data) (full 2*DATA_W signed product, accumulated modulo 2^ACC_W). w_addr<=w_addr+1 unconditionally. If i==N_IN-1: -> WRITE, x_addr<=0, i<=0. Else i<=i+1, x_addr<=x_addr+1.
- WRITE, one edge: y_data <= sat(acc >>> FRAC_BITS) clipped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; y_index<=neuron; y_valid<=1 (cleared next edge); acc<=0. If neuron==N_OUT-1: -> DONE. Else neuron<=neuron+1, -> RUN. w_addr already points to the next row start.
- DONE, one edge: done<=1 (one cycle), busy<=0, w_addr<=0, -> IDLE.
- Timing with start accepted at edge 0: y_valid for neuron k is high in the cycle after edge (k+1)*(N_IN+1). done is high in the cycle after edge N_OUT*(N_IN+1)+1. A new start is accepted at that same edge or later.
- start while busy: ignored, no effect.
- Arithmetic shift is sign-preserving (floor toward -inf). No rounding.
- w_addr/x_addr are meaningful only while in RUN. The last w_addr driven in RUN is N_IN*N_OUT-1.

Optional Feature:
RELU_EN: when defined, the WRITE-stage result is max(sat(acc>>>FRAC_BITS), 0), so a negative result outputs 0. When undefined, the signed saturated value is output unchanged. Timing is identical in both cases.

Test Plan (N_IN=4, N_OUT=3, FRAC_BITS=16, behavioural comb ROM/vector models):
1. All weights 0x00010000, x={1.0,2.0,3.0,4.0} (0x00010000..0x00040000), start pulse -> three y_valid pulses at cycles after edges 5,10,15, y_index 0,1,2, y_data=0x000A0000. done is high after edge 16. busy spans edges 0..16.
2. Address trace in the same run -> w_addr in RUN cycles = 0..11 contiguous; x_addr = 0,1,2,3 repeated three times; w_addr=0 after done.
3. Row 1 weights 0xFFFF0000 (-1.0), others 1.0 -> y_data[1]=0xFFF60000 without RELU_EN, 0x00000000 with RELU_EN; rows 0 and 2 = 0x000A0000.
4. Saturation: x={0x7FFFFFFF,0,0,0}, row 0 weight0=0x7FFFFFFF -> y_data[0]=0x7FFFFFFF. With row 0 weight0=0x80000001 -> y_data[0]=0x80000000 without RELU_EN.
5. start held high through the run, plus a second start pulse at edge 7 -> exactly 3 y_valid and 1 done. A fresh layer begins only at an edge when state is IDLE.
6. resetn low at edge 7 (mid neuron 1) -> all outputs 0 immediately (async), no further y_valid. Restart after release -> correct results as in test 1.

Source files
------------

// File: rtl/layer1_mac_engine_if.sv
// Bus bundle between the layer-1 MAC engine and its environment:
// start control, weight ROM / input-vector read ports, result stream, status.
interface layer1_mac_engine_if #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned X_ADDR_W = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 6
);
    logic                start;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [X_ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0]   x_data;
    logic                y_valid;
    logic [IDX_W-1:0]    y_index;
    logic [DATA_W-1:0]   y_data;
    logic                busy;
    logic                done;

    // Engine side: drives addresses and results, reads memories and start
    modport master (
        input  start, w_data, x_data,
        output w_addr, x_addr, y_valid, y_index, y_data, busy, done
    );

    // Environment side: memories, start source and result sink
    modport slave (
        output start, w_data, x_data,
        input  w_addr, x_addr, y_valid, y_index, y_data, busy, done
    );
endinterface

// File: rtl/layer1_mac_engine.sv
// Layer-1 fully connected MAC engine: walks the row-major weight ROM and the
// input vector, accumulates one dot product per neuron, and emits each result
// shifted down by FRAC_BITS and saturated to DATA_W with a one-cycle valid.
// Optional macro RELU_EN clamps negative results to zero (timing unchanged).
module layer1_mac_engine #(
    parameter int unsigned N_IN      = 784,
    parameter int unsigned N_OUT     = 64,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned X_ADDR_W  = 10,
    parameter int unsigned ACC_W     = 64
) (
    input  logic               clk,
    input  logic               resetn,
    layer1_mac_engine_if.master bus
);
    localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned HI_W   = ACC_W - DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic [X_ADDR_W-1:0]        i_q;
    logic [IDX_W-1:0]           neuron_q;
    logic [ADDR_W-1:0]          w_addr_q;
    logic [X_ADDR_W-1:0]        x_addr_q;
    logic [IDX_W-1:0]           y_index_q;
    logic [DATA_W-1:0]          y_data_q;
    logic                       y_valid_q;
    logic                       busy_q;
    logic                       done_q;

    logic signed [PROD_W-1:0]   prod_c;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    shifted_c;
    logic [HI_W-1:0]            sat_hi_c;
    logic                       fits_c;
    logic [DATA_W-1:0]          y_sat_c;
    logic [DATA_W-1:0]          y_data_d;

    // Full-width signed product and running sum (wraps modulo 2^ACC_W)
    always_comb begin
        prod_c = PROD_W'($signed(bus.w_data)) * PROD_W'($signed(bus.x_data));
        acc_d  = acc_q + ACC_W'(prod_c);
    end

    // Fixed-point rescale (arithmetic shift, floor) and saturation to DATA_W
    always_comb begin
        shifted_c = acc_q >>> FRAC_BITS;
        sat_hi_c  = shifted_c[ACC_W-1:DATA_W-1];
        fits_c    = (&sat_hi_c) | ~(|sat_hi_c);
        if (fits_c) begin
            y_sat_c = shifted_c[DATA_W-1:0];
        end else if (shifted_c[ACC_W-1]) begin
            y_sat_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y_sat_c = {1'b0, {(DATA_W-1){1'b1}}};
        end
`ifdef RELU_EN
        y_data_d = y_sat_c[DATA_W-1] ? '0 : y_sat_c;
`else
        y_data_d = y_sat_c;
`endif
    end

    // Sequencer: state, counters, addresses, accumulator and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            i_q       <= '0;
            neuron_q  <= '0;
            w_addr_q  <= '0;
            x_addr_q  <= '0;
            y_index_q <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        acc_q    <= '0;
                        i_q      <= '0;
                        neuron_q <= '0;
                        w_addr_q <= '0;
                        x_addr_q <= '0;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    w_addr_q <= w_addr_q + ADDR_W'(1);
                    if (i_q == X_ADDR_W'(N_IN - 1)) begin
                        state_q  <= S_WRITE;
                        i_q      <= '0;
                        x_addr_q <= '0;
                    end else begin
                        i_q      <= i_q + X_ADDR_W'(1);
                        x_addr_q <= x_addr_q + X_ADDR_W'(1);
                    end
                end
                S_WRITE: begin
                    y_data_q  <= y_data_d;
                    y_index_q <= neuron_q;
                    y_valid_q <= 1'b1;
                    acc_q     <= '0;
                    if (neuron_q == IDX_W'(N_OUT - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        neuron_q <= neuron_q + IDX_W'(1);
                        state_q  <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    w_addr_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Drive the bus from registers only
    assign bus.w_addr  = w_addr_q;
    assign bus.x_addr  = x_addr_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_index = y_index_q;
    assign bus.y_data  = y_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_layer1_mac_engine.sv
// Directed + randomized bench for layer1_mac_engine (N_IN=4, N_OUT=3).
module tb_layer1_mac_engine;
    localparam int N_IN      = 4;
    localparam int N_OUT     = 3;
    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;
    localparam int ADDR_W    = 16;
    localparam int X_ADDR_W  = 10;
    localparam int ACC_W     = 64;
    localparam int IDX_W     = 2;
    localparam int P         = N_IN + 1;
    localparam int NW        = N_IN * N_OUT;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    layer1_mac_engine_if #(.ADDR_W(ADDR_W), .X_ADDR_W(X_ADDR_W),
                           .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    layer1_mac_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS),
        .ADDR_W(ADDR_W), .X_ADDR_W(X_ADDR_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    logic [31:0] w_mem [NW];
    logic [31:0] x_mem [N_IN];
    logic [31:0] exp_y [N_OUT];
    int wi, xi;

    // Combinational weight ROM and input-vector store
    always_comb begin
        wi = int'(bus.w_addr);
        xi = int'(bus.x_addr);
        bus.w_data = (wi < NW)   ? w_mem[wi] : '0;
        bus.x_data = (xi < N_IN) ? x_mem[xi] : '0;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: plain integer dot product, floor shift, clamp, optional ReLU
    function automatic logic [31:0] model(input int k);
        longint acc = 0;
        longint r;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(w_mem[k*N_IN+i])) * longint'($signed(x_mem[i]));
        r = acc >>> FRAC_BITS;
        if (r > 64'sd2147483647)       r = 64'sd2147483647;
        else if (r < -64'sd2147483648) r = -64'sd2147483648;
`ifdef RELU_EN
        if (r < 0) r = 0;
`endif
        return r[31:0];
    endfunction

    task automatic fill_model();
        for (int k = 0; k < N_OUT; k++) exp_y[k] = model(k);
    endtask

    task automatic set_unit();
        for (int j = 0; j < NW; j++) w_mem[j] = 32'h0001_0000;
        for (int i = 0; i < N_IN; i++) x_mem[i] = 32'((i + 1) << 16);
    endtask

    // mode 0: single pulse; 1: start held high; 2: extra pulses at edges 3 and 7
    task automatic run_layer(input int mode, input bit trace);
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int n = 0; n <= N_OUT*P + 2; n++) begin
            bit ev;
            @(posedge clk); #1;
            ev = (n >= P) && (n <= N_OUT*P) && (n % P == 0);
            chk("y_valid", 64'(bus.y_valid), 64'(ev));
            chk("done", 64'(bus.done), 64'(n == N_OUT*P + 1));
            chk("busy", 64'(bus.busy), 64'(n <= N_OUT*P));
            if (ev) begin
                chk("y_index", 64'(bus.y_index), 64'(n / P - 1));
                chk("y_data", 64'(bus.y_data), 64'(exp_y[n / P - 1]));
            end
            if (trace && n < N_OUT*P && (n % P) != P - 1) begin
                chk("w_addr", 64'(bus.w_addr), 64'((n / P) * N_IN + n % P));
                chk("x_addr", 64'(bus.x_addr), 64'(n % P));
            end
            if (trace && n == N_OUT*P + 1)
                chk("w_addr_after_done", 64'(bus.w_addr), 64'(0));
            case (mode)
                0:       bus.start = 1'b0;
                1:       bus.start = (n < N_OUT*P - 1);
                default: bus.start = (n == 2 || n == 6);
            endcase
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_w_addr"},  64'(bus.w_addr),  64'(0));
        chk({tag, "_x_addr"},  64'(bus.x_addr),  64'(0));
        chk({tag, "_y_index"}, 64'(bus.y_index), 64'(0));
        chk({tag, "_y_data"},  64'(bus.y_data),  64'(0));
        chk({tag, "_y_valid"}, 64'(bus.y_valid), 64'(0));
        chk({tag, "_busy"},    64'(bus.busy),    64'(0));
        chk({tag, "_done"},    64'(bus.done),    64'(0));
    endtask

    initial begin
        bus.start = 1'b0;
        set_unit();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1/2: unit weights, address trace
        for (int k = 0; k < N_OUT; k++) exp_y[k] = 32'h000A_0000;
        run_layer(0, 1'b1);

        // 3: negative row
        for (int i = 0; i < N_IN; i++) w_mem[N_IN + i] = 32'hFFFF_0000;
        exp_y[0] = 32'h000A_0000;
`ifdef RELU_EN
        exp_y[1] = 32'h0000_0000;
`else
        exp_y[1] = 32'hFFF6_0000;
`endif
        exp_y[2] = 32'h000A_0000;
        run_layer(0, 1'b0);

        // 4: positive and negative saturation
        set_unit();
        x_mem[0] = 32'h7FFF_FFFF;
        for (int i = 1; i < N_IN; i++) x_mem[i] = '0;
        w_mem[0] = 32'h7FFF_FFFF;
        for (int k = 0; k < N_OUT; k++) exp_y[k] = 32'h7FFF_FFFF;
        run_layer(0, 1'b0);
        w_mem[0] = 32'h8000_0001;
`ifdef RELU_EN
        exp_y[0] = 32'h0000_0000;
`else
        exp_y[0] = 32'h8000_0000;
`endif
        run_layer(0, 1'b0);

        // 5: start held high, then extra pulses while busy
        set_unit();
        for (int k = 0; k < N_OUT; k++) exp_y[k] = 32'h000A_0000;
        run_layer(1, 1'b1);
        run_layer(2, 1'b1);

        // randomized layers: small-range values, then full-range values
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < NW; j++)
                w_mem[j] = (r < 4) ? 32'(int'($urandom_range(0, 32'h0007_FFFF)) - 32'sh0004_0000) : $urandom();
            for (int i = 0; i < N_IN; i++)
                x_mem[i] = (r < 4) ? 32'(int'($urandom_range(0, 32'h0007_FFFF)) - 32'sh0004_0000) : $urandom();
            fill_model();
            run_layer(r % 3, 1'b1);
        end

        // 6: async reset mid neuron 1, then clean restart
        set_unit();
        for (int k = 0; k < N_OUT; k++) exp_y[k] = 32'h000A_0000;
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int n = 0; n <= 6; n++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        #3 resetn = 1'b0;
        #1 chk_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("held_reset");
        resetn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            chk("post_reset_y_valid", 64'(bus.y_valid), 64'(0));
            chk("post_reset_busy", 64'(bus.busy), 64'(0));
        end
        run_layer(0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
